lfsr_checker: RTL and testbench
===============================

// Module: lfsr_checker
// PURPOSE
//  Serial receiver/checker for the 4-bit XNOR LFSR pattern (x^4+x^3+1, next = {s[2:0], ~(s[3]^s[2])}).
//  Consumes one received pattern bit per valid cycle, self-synchronises to the sequence and counts bit errors.
//  Sits at the far end of a link or loopback driven by the LFSR generator, for link/BIST checking.
//  Reference sequence after generator reset (period 15): 1,1,1,0,1,1,0,0,1,0,1,0,0,0,0.
// PARAMETERS
//  CNT_W        16  width of err_count; saturates at all-ones
//  SYNC_GOOD    4   consecutive correct predictions required in VERIFY before locked
//  LOSS_THRESH  3   consecutive mismatches in LOCKED that drop lock (>=1)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      asynchronous active-high reset
//  din_valid  in   1      din carries a pattern bit this cycle
//  din        in   1      received pattern bit (generator's newly inserted bit)
//  clr_cnt    in   1      synchronous clear of err_count and lockup flag
//  locked     out  1      checker synchronised to the sequence
//  err_pulse  out  1      one-cycle pulse: previous valid bit mismatched while locked
//  err_count  out  CNT_W  saturating count of mismatches while locked
//  lockup     out  1      sticky all-ones lockup detected (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=HUNT, shift reg sh=0, fill/match/miss counters 0, locked=0, err_pulse=0, err_count=0, lockup=0.
//  Only cycles with din_valid=1 advance anything; din_valid=0 holds all state, err_pulse=0.
//  HUNT: shift din into sh (sh<={sh[2:0],din}); after 4th valid bit -> VERIFY, match count 0.
//  VERIFY: pred=~(sh[3]^sh[2]); sh<={sh[2:0],din} (self-sync from received data).
//   din==pred: match++; on reaching SYNC_GOOD -> LOCKED. din!=pred: match=0, stay VERIFY.
//  LOCKED: sh free-runs as local LFSR (sh<={sh[2:0],pred}); received bits never reseed it.
//   din!=pred: err_pulse=1 next cycle, err_count++ (saturate), miss++.
//   din==pred: miss=0. miss reaching LOSS_THRESH -> HUNT, fill count 0, locked=0 next cycle.
//  locked registered: high the cycle after the valid bit that completes SYNC_GOOD.
//  From reset-aligned stream: locked rises after 8th valid bit (4 fill + 4 matches).
//  Mismatches in HUNT/VERIFY never pulse err_pulse nor count.
//  clr_cnt with a simultaneous error: clear wins, err_count=0 (err_pulse still fires).
//  err_count at all-ones: holds; err_pulse still fires.
//  rst mid-operation: immediate return to reset values regardless of state.
// CONFIGURATION
//  Macro LFSR_CHK_LOCKUP_DET_EN:
//   defined: sh==4'b1111 after any update (impossible in legal XNOR sequence) sets lockup (sticky
//    until clr_cnt/rst); in VERIFY a 1111 sh forces match=0 so lock is never acquired on lockup state;
//    in LOCKED forces -> HUNT next cycle.
//   undefined: lockup tied 0; no 1111 special-casing.
// STRUCTURE
//  Package lfsr_pkg: LFSR_W=4, tap constants, lfsr_next(s) function, state enum {HUNT,VERIFY,LOCKED}.
//  lfsr_next shared with generator so both ends use one polynomial definition.
//  Sub-module sat_counter (width param, inc, clr, saturate) for err_count; rest in one module.
// TESTING
//  Reset, then 30 valid bits of reference seq -> locked=1 after 8th bit, err_count=0, err_pulse never 1.
//  Locked, flip bit 12 -> single err_pulse one cycle later, err_count=1, locked stays 1.
//  Locked, 3 consecutive flipped bits -> err_count=3, locked=0 after 3rd; clean bits relock after 8 more.
//  din_valid toggled 1/0 every cycle on clean seq -> locks after 8 valid bits, no errors.
//  Stream starting at offset 5 of sequence -> locks after 8 bits; rst mid-lock -> locked=0 immediately.
//  Feed constant 1s with LFSR_CHK_LOCKUP_DET_EN -> lockup=1, never locked; without macro lockup=0.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 4-bit XNOR LFSR (x^4+x^3+1) used by generator and checker.
package lfsr_pkg;

  localparam int unsigned LFSR_W = 4;
  localparam int unsigned TAP_HI = 3;
  localparam int unsigned TAP_LO = 2;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  // One LFSR step: shift left, insert XNOR of the two taps.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ~(s[TAP_HI] ^ s[TAP_LO])};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear has priority over increment).
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear, else increment unless already at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising serial checker for the 4-bit XNOR LFSR pattern.
// Optional all-ones lockup detection is built when LFSR_CHK_LOCKUP_DET_EN is defined.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_GOOD   = 4,
  parameter int unsigned LOSS_THRESH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic             lockup
);

  localparam int unsigned FILL_W  = 3;
  localparam int unsigned MATCH_W = $clog2(SYNC_GOOD + 1);
  localparam int unsigned MISS_W  = $clog2(LOSS_THRESH + 1);

  chk_state_e          state_q, state_d;
  logic [LFSR_W-1:0]   sh_q, sh_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic                locked_q, locked_d;
  logic                err_pulse_q, err_pulse_d;
  logic                err_inc;

  logic [LFSR_W-1:0]   sh_next;
  logic                pred;
  logic [MATCH_W-1:0]  match_inc;
  logic [MISS_W-1:0]   miss_inc;

  assign sh_next   = lfsr_next(sh_q);
  assign pred      = sh_next[0];
  assign match_inc = match_q + MATCH_W'(1);
  assign miss_inc  = miss_q + MISS_W'(1);

  // Sync FSM next state: fill, verify predictions, then free-run and count errors.
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    fill_d      = fill_q;
    match_d     = match_q;
    miss_d      = miss_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    err_inc     = 1'b0;
    if (din_valid) begin
      case (state_q)
        HUNT: begin
          sh_d   = {sh_q[LFSR_W-2:0], din};
          fill_d = fill_q + FILL_W'(1);
          if (fill_q == FILL_W'(LFSR_W - 1)) begin
            state_d = VERIFY;
            match_d = '0;
          end
        end
        VERIFY: begin
          sh_d = {sh_q[LFSR_W-2:0], din};
          if (din == pred) begin
            match_d = match_inc;
            if (match_inc == MATCH_W'(SYNC_GOOD)) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              miss_d   = '0;
            end
          end else begin
            match_d = '0;
          end
`ifdef LFSR_CHK_LOCKUP_DET_EN
          // Never acquire lock on the XNOR lockup state.
          if (sh_d == {LFSR_W{1'b1}}) begin
            match_d  = '0;
            state_d  = VERIFY;
            locked_d = 1'b0;
          end
`endif
        end
        LOCKED: begin
          sh_d = sh_next;
          if (din != pred) begin
            err_pulse_d = 1'b1;
            err_inc     = 1'b1;
            miss_d      = miss_inc;
            if (miss_inc == MISS_W'(LOSS_THRESH)) begin
              state_d  = HUNT;
              fill_d   = '0;
              miss_d   = '0;
              locked_d = 1'b0;
            end
          end else begin
            miss_d = '0;
          end
`ifdef LFSR_CHK_LOCKUP_DET_EN
          // A stuck local LFSR cannot track anything; resynchronise.
          if (sh_d == {LFSR_W{1'b1}}) begin
            state_d  = HUNT;
            fill_d   = '0;
            miss_d   = '0;
            locked_d = 1'b0;
          end
`endif
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      sh_q        <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  // Error counter, saturating at all-ones.
  sat_counter #(
    .W(CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (err_inc),
    .clr  (clr_cnt),
    .count(err_count)
  );

`ifdef LFSR_CHK_LOCKUP_DET_EN
  logic lockup_q, lockup_d;

  // Sticky lockup flag: set when the shift register lands on all-ones, clear wins.
  always_comb begin
    lockup_d = lockup_q;
    if (din_valid && (sh_d == {LFSR_W{1'b1}})) begin
      lockup_d = 1'b1;
    end
    if (clr_cnt) begin
      lockup_d = 1'b0;
    end
  end

  // Lockup flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lockup_q <= 1'b0;
    end else begin
      lockup_q <= lockup_d;
    end
  end

  assign lockup = lockup_q;
`else
  assign lockup = 1'b0;
`endif

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed scoreboard bench for lfsr_checker (narrow counter to reach saturation quickly).
module tb_lfsr_checker;

  localparam int unsigned CNT_W = 4;
`ifdef LFSR_CHK_LOCKUP_DET_EN
  localparam bit LK = 1'b1;
`else
  localparam bit LK = 1'b0;
`endif

  typedef struct packed {
    logic             locked;
    logic             pulse;
    logic [CNT_W-1:0] cnt;
    logic             lockup;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             din_valid;
  logic             din;
  logic             clr_cnt;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
  logic             lockup;

  exp_t       sb[$];
  int         errors;
  int         checks;
  int         pos;
  int         nvalid;
  logic [0:14] ref_seq;

  lfsr_checker #(
    .CNT_W      (CNT_W),
    .SYNC_GOOD  (4),
    .LOSS_THRESH(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din_valid(din_valid),
    .din      (din),
    .clr_cnt  (clr_cnt),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_count(err_count),
    .lockup   (lockup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle, queue its expected outcome, then compare after the edge.
  task automatic step(input logic v, input logic d, input logic c, input logic el,
                      input logic ep, input logic [CNT_W-1:0] ec, input logic elk,
                      input string tag);
    exp_t e;
    din_valid = v;
    din       = d;
    clr_cnt   = c;
    e.locked  = el;
    e.pulse   = ep;
    e.cnt     = ec;
    e.lockup  = elk;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".locked"}, 16'(locked), 16'(e.locked));
    chk({tag, ".err_pulse"}, 16'(err_pulse), 16'(e.pulse));
    chk({tag, ".err_count"}, 16'(err_count), 16'(e.cnt));
    chk({tag, ".lockup"}, 16'(lockup), 16'(e.lockup));
    din_valid = 1'b0;
    clr_cnt   = 1'b0;
  endtask

  // Send the next reference bit, optionally inverted.
  task automatic send(input logic flip, input logic c, input logic el, input logic ep,
                      input logic [CNT_W-1:0] ec, input logic elk, input string tag);
    step(1'b1, ref_seq[pos] ^ flip, c, el, ep, ec, elk, tag);
    pos = (pos + 1) % 15;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int sat;
    errors    = 0;
    checks    = 0;
    ref_seq   = 15'b111011001010000;
    rst       = 1'b1;
    din_valid = 1'b0;
    din       = 1'b0;
    clr_cnt   = 1'b0;
    #12;
    chk("reset.locked", 16'(locked), 16'd0);
    chk("reset.err_pulse", 16'(err_pulse), 16'd0);
    chk("reset.err_count", 16'(err_count), 16'd0);
    chk("reset.lockup", 16'(lockup), 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Clean reference stream from reset alignment: lock after the 8th bit.
    pos = 0;
    for (int i = 0; i < 30; i++) send(1'b0, 1'b0, (i + 1) >= 8, 1'b0, '0, 1'b0, "ref30");

    // Single flipped bit while locked.
    for (int j = 0; j < 20; j++)
      send(j == 11, 1'b0, 1'b1, j == 11, (j >= 11) ? CNT_W'(1) : CNT_W'(0), 1'b0, "flip12");

    // Clear, three consecutive errors drop lock, then relock on clean data.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, "clr");
    for (int k = 0; k < 3; k++) send(1'b1, 1'b0, k < 2, 1'b1, CNT_W'(k + 1), 1'b0, "loss3");
    for (int i = 0; i < 12; i++) send(1'b0, 1'b0, (i + 1) >= 8, 1'b0, CNT_W'(3), 1'b0, "relock");

    // Clear coinciding with an error: clear wins, pulse still fires.
    send(1'b1, 1'b1, 1'b1, 1'b1, CNT_W'(0), 1'b0, "clr_vs_err");
    send(1'b1, 1'b0, 1'b1, 1'b1, CNT_W'(1), 1'b0, "err_after_clr");
    send(1'b0, 1'b0, 1'b1, 1'b0, CNT_W'(1), 1'b0, "clean_after_clr");

    // Alternate errors with clean bits to reach saturation without losing lock.
    for (int k = 0; k < 18; k++) begin
      sat = (k + 2 > 15) ? 15 : (k + 2);
      send(1'b1, 1'b0, 1'b1, 1'b1, CNT_W'(sat), 1'b0, "sat_err");
      send(1'b0, 1'b0, 1'b1, 1'b0, CNT_W'(sat), 1'b0, "sat_clean");
    end

    // Asynchronous reset while locked takes effect without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async.locked", 16'(locked), 16'd0);
    chk("rst_async.err_count", 16'(err_count), 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // din_valid toggling: only valid cycles advance.
    pos    = 0;
    nvalid = 0;
    for (int i = 0; i < 22; i++) begin
      if ((i % 2) == 0) begin
        nvalid++;
        send(1'b0, 1'b0, nvalid >= 8, 1'b0, '0, 1'b0, "toggle_v");
      end else begin
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0, nvalid >= 8, 1'b0, '0, 1'b0, "toggle_i");
      end
    end

    // Stream starting at offset 5, then reset mid-lock.
    do_reset();
    pos = 5;
    for (int i = 0; i < 12; i++) send(1'b0, 1'b0, (i + 1) >= 8, 1'b0, '0, 1'b0, "offset5");
    #2;
    rst = 1'b1;
    #1;
    chk("rst_midlock.locked", 16'(locked), 16'd0);
    chk("rst_midlock.err_pulse", 16'(err_pulse), 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Constant ones: the XNOR lockup state.
    for (int i = 0; i < 12; i++)
      step(1'b1, 1'b1, 1'b0, LK ? 1'b0 : ((i + 1) >= 8), 1'b0, '0,
           LK ? ((i + 1) >= 4) : 1'b0, "ones");
    step(1'b0, 1'b1, 1'b1, LK ? 1'b0 : 1'b1, 1'b0, '0, 1'b0, "ones_clr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
